dcache_wb_dm: RTL
=================

# dcache_wb_dm

Direct-mapped, write-back, write-allocate data cache that sits between the MIPS core's load/store port and the `slow_memory` block. It is the initiator on the 128-bit block interface (`mem_read`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata`/`mem_ready`). It serves word accesses from the core and stalls the core on misses.

## Interface
- `NUM_BLOCKS`, 8: number of cache lines (power of two); index width `IDX = log2(NUM_BLOCKS)`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `proc_read` input 1: core load request.
- `proc_write` input 1: core store request (never both with `proc_read`).
- `proc_addr` input 30: word address; [1:0] word-in-block, [IDX+1:2] index, [29:IDX+2] tag.
- `proc_wdata` input 32: store data.
- `proc_rdata` output 32: load data; valid when `proc_stall`=0 and `proc_read`=1.
- `proc_stall` output 1: 1 while the current request is not yet serviced.
- `mem_read` output 1: block read request to memory.
- `mem_write` output 1: block write request to memory.
- `mem_addr` output 28: block address (byte address [31:4]).
- `mem_wdata` output 128: victim block; word 0 in [31:0], word 3 in [127:96].
- `mem_rdata` input 128: fill block, same word ordering.
- `mem_ready` input 1: one-cycle pulse; memory has completed the request.

## Operation
- Per line storage: valid, dirty, tag (`28-IDX` bits), 128-bit data.
- States: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE with no request: idle, `proc_stall`=0, no memory request.
- COMPARE, hit (valid and tag match):
  - Read: `proc_rdata` = selected word, combinational from storage.
  - Write: selected word updated at the clock edge and dirty set. The other three words are unchanged.
  - `proc_stall`=0 in the same cycle.
- COMPARE, miss:
  - `proc_stall`=1.
  - If the line is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - `mem_write`=1, `mem_addr`={stored tag, index}, `mem_wdata`=line data.
  - All three are held constant until `mem_ready`=1 is sampled, then go to ALLOCATE.
- ALLOCATE:
  - `mem_read`=1, `mem_addr`=`proc_addr[29:2]`, held until `mem_ready`=1.
  - On that edge: line data ← `mem_rdata`, valid=1, dirty=0, tag written, go to COMPARE.
- Back in COMPARE the request now hits and completes as above. A write miss therefore ends with a dirty line containing the merged word.
- `mem_read` and `mem_write` are never both 1.
- Request outputs are registered. They drop on the edge where `mem_ready` is sampled, so no second request is issued.
- The core holds `proc_read`/`proc_write`/`proc_addr`/`proc_wdata` stable while `proc_stall`=1. The cache does not latch them.
- Index and tag widths follow `NUM_BLOCKS`. `mem_addr` is always exactly 28 bits, with no truncation or extension.

## Timing
- Reset values:
  - `proc_stall`=0, `mem_read`=0, `mem_write`=0.
  - `mem_addr` and `mem_wdata` = 0.
  - `proc_rdata` = 0 while idle.
  - State COMPARE; all valid and dirty bits = 0.
  - Data and tag arrays need not be cleared.
- Hit latency: 0 stall cycles; the request completes in its presenting cycle.
- Clean miss: stall = 1 (COMPARE) + N_rd (ALLOCATE cycles up to and including `mem_ready`) + 0 (COMPARE hit). `proc_stall` falls in the cycle after the fill edge.
- Dirty miss: stall = 1 + N_wr + N_rd.
- `mem_ready` arriving in COMPARE is ignored.
- `mem_ready` held high across two cycles counts only once per state entry.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE:
  - Immediately (asynchronously) drops `mem_read`/`mem_write`/`proc_stall` and invalidates all lines.
  - The pending memory transaction is abandoned.
- Requests to the same index back-to-back are handled independently. A hit on the line just filled is legal in the first COMPARE cycle.

## Test plan
- Read-miss fill:
  - After reset, `proc_read`, `proc_addr`=0x00000004 (index 1, word 0). Expect `proc_stall`=1 and `mem_read`=1 with `mem_addr`=0x0000001.
  - Memory returns 0x44443333222211110000000000000000, i.e. word 3 = 0x44443333, word 2 = 0x22221111, words 1 and 0 = 0x00000000.
  - Expect `proc_rdata`=0x00000000 in the cycle after `mem_ready` with `proc_stall`=0. A following read of 0x00000006 (word 2) returns 0x22221111 with no stall.
- Write hit then eviction:
  - Write 0xDEADBEEF to 0x00000005. This is a hit, so no memory traffic.
  - Read 0x00000025 (same index, different tag). Expect `mem_write`=1, `mem_addr`=0x0000001.
  - Expect `mem_wdata`[63:32]=0xDEADBEEF, then `mem_read` with `mem_addr`=0x0000009.
- Write miss on clean line:
  - Write 0x12345678 to 0x00000040. Expect allocate only, with no `mem_write`.
  - Then read 0x00000040: returns 0x12345678 with 0 stall.
- Slow memory: `mem_ready` delayed 10 cycles. `mem_read`/`mem_addr` stay stable for all 10 cycles and drop the cycle after `mem_ready`. Exactly one request is issued.
- Reset mid-allocate: assert `rst` 3 cycles into ALLOCATE. Expect `mem_read`=0 and `proc_stall`=0 immediately, and the next access to the same address misses again.
- No-request idle: `proc_read`=`proc_write`=0 for 20 cycles. Expect no `mem_read`/`mem_write` and `proc_stall`=0 throughout.

Source files
------------

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the core load/store port
// and a 128-bit block memory. Misses stall the core while a dirty victim is written back and the line is refilled.
module dcache_wb_dm #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int IDX  = $clog2(NUM_BLOCKS);
  localparam int TAGW = 28 - IDX;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e              state_q, state_d;
  logic [NUM_BLOCKS-1:0] valid_q, dirty_q;
  logic [TAGW-1:0]     tag_q  [NUM_BLOCKS];
  logic [127:0]        data_q [NUM_BLOCKS];

  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic [27:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;
  logic         rdy_q;

  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] tag;
  logic [1:0]      word;
  logic            hit, rdy_pulse, fill, wr_hit, stall_c;
  logic [31:0]     rdata_c;

  assign idx       = proc_addr[IDX+1:2];
  assign tag       = proc_addr[29:IDX+2];
  assign word      = proc_addr[1:0];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  // A ready level held across cycles is one completion, so only its first cycle counts.
  assign rdy_pulse = mem_ready && !rdy_q;

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill        = 1'b0;
    wr_hit      = 1'b0;
    stall_c     = 1'b0;
    rdata_c     = 32'h0;
    case (state_q)
      COMPARE: begin
        if (proc_read || proc_write) begin
          if (hit) begin
            if (proc_read) rdata_c = data_q[idx][{word, 5'b0} +: 32];
            else           wr_hit  = 1'b1;
          end else begin
            stall_c = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d     = WRITEBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {tag_q[idx], idx};
              mem_wdata_d = data_q[idx];
            end else begin
              state_d    = ALLOCATE;
              mem_read_d = 1'b1;
              mem_addr_d = proc_addr[29:2];
            end
          end
        end
      end
      WRITEBACK: begin
        stall_c = 1'b1;
        if (rdy_pulse) begin
          state_d     = ALLOCATE;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = proc_addr[29:2];
        end
      end
      ALLOCATE: begin
        stall_c = 1'b1;
        if (rdy_pulse) begin
          state_d    = COMPARE;
          mem_read_d = 1'b0;
          fill       = 1'b1;
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COMPARE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 28'h0;
      mem_wdata_q <= 128'h0;
      valid_q     <= '0;
      dirty_q     <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdy_q       <= mem_ready;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tags and data are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (wr_hit) begin
      data_q[idx][{word, 5'b0} +: 32] <= proc_wdata;
    end
  end

  assign proc_stall = stall_c && !rst;
  assign proc_rdata = rdata_c;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
